// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the CPU-to-SPI-SRAM bridge: FSM states,
// SPI byte-count encodings and the lane/byte-order conversions.
package sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_GAP,
    ST_RESP
  } state_t;

  localparam logic [1:0] MASK_1B = 2'b00;
  localparam logic [1:0] MASK_2B = 2'b01;
  localparam logic [1:0] MASK_4B = 2'b10;

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // SPI shifts MSB first, so lane(off) must sit in bits 31:24.
  function automatic logic [31:0] spi_wdata(input logic [31:0] wdata,
                                            input logic [1:0]  off,
                                            input logic [1:0]  mask);
    logic [31:0] msb_first;
    logic [31:0] res;
    msb_first = byte_swap(wdata >> {off, 3'b000});
    case (mask)
      MASK_1B: res = msb_first & 32'hFF00_0000;
      MASK_2B: res = msb_first & 32'hFFFF_0000;
      default: res = msb_first;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sram_bridge_if.sv
// CPU request/response and spi_master command/status bundle.
// slave = bridge view, master = CPU plus spi_master view.
interface sram_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        spi_reset;
  logic [23:0] spi_addr;
  logic [31:0] spi_data_in;
  logic [1:0]  spi_byte_mask;
  logic        spi_write;
  logic [31:0] spi_data_out;
  logic        spi_busy;
  logic        spi_valid;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  spi_data_out, spi_busy, spi_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output spi_reset, spi_addr, spi_data_in, spi_byte_mask, spi_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output spi_data_out, spi_busy, spi_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  spi_reset, spi_addr, spi_data_in, spi_byte_mask, spi_write
  );
endinterface

// File: rtl/sram_bridge_strobe_decode.sv
// Combinational strobe decode: next SPI transaction offset, byte count and lanes consumed.
// Zero latency; no handshake. Irregular strobes (or loop_i) fall back to lowest single byte.
module sram_strobe_decode
  import sram_bridge_pkg::*;
(
  input  logic [3:0] strb_i,
  input  logic       loop_i,
  output logic       direct_o,
  output logic [1:0] offset_o,
  output logic [1:0] mask_o,
  output logic [3:0] consume_o
);

  logic [1:0] lo_off;
  logic [3:0] lo_bit;
  logic [1:0] pat_mask;

  always_comb begin
    lo_off = 2'd0;
    lo_bit = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      if (strb_i[k]) begin
        lo_off = 2'(k);
        lo_bit = 4'b0001 << k;
      end
    end
  end

  always_comb begin
    direct_o = 1'b1;
    pat_mask = MASK_1B;
    case (strb_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: pat_mask = MASK_1B;
      4'b0011, 4'b0110, 4'b1100:          pat_mask = MASK_2B;
      4'b1111:                            pat_mask = MASK_4B;
      default:                            direct_o = 1'b0;
    endcase
  end

  always_comb begin
    offset_o = lo_off;
    if (loop_i || !direct_o) begin
      mask_o    = MASK_1B;
      consume_o = lo_bit;
    end else begin
      mask_o    = pat_mask;
      consume_o = strb_i;
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// Bridges single CPU word requests onto a start/done spi_master, splitting strobes into SPI bursts.
// One request in flight: req_ready only in IDLE; one-cycle rsp_valid pulse, timeout flagged via rsp_err.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  sram_bridge_if.slave bus
);

  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state_q;
  logic [21:0]      word_q;
  logic [31:0]      wdata_q;
  logic             write_q;
  logic             loop_q;
  logic             err_q;
  logic [3:0]       rem_q;
  logic [31:0]      rdata_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [7:0]       gap_cnt_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;
  logic             spi_reset_q;
  logic [23:0]      spi_addr_q;
  logic [31:0]      spi_data_in_q;
  logic [1:0]       spi_byte_mask_q;
  logic             spi_write_q;

  logic        idle;
  logic        gap_end;
  logic        launch_go;
  logic [3:0]  dec_strb;
  logic        dec_loop;
  logic        dec_direct;
  logic [1:0]  dec_offset;
  logic [1:0]  dec_mask;
  logic [3:0]  dec_consume;
  logic [21:0] cmd_word;
  logic [31:0] cmd_wdata;
  logic        cmd_write;
  logic [31:0] cmd_data_in;

  // In IDLE the command is built straight from the live request so LAUNCH can drive it.
  assign idle        = (state_q == ST_IDLE);
  assign dec_strb    = idle ? (bus.req_write ? bus.req_wstrb : 4'hF) : rem_q;
  assign dec_loop    = idle ? 1'b0 : loop_q;
  assign cmd_word    = idle ? bus.req_addr[23:2] : word_q;
  assign cmd_wdata   = idle ? bus.req_wdata : wdata_q;
  assign cmd_write   = idle ? bus.req_write : write_q;
  assign cmd_data_in = cmd_write ? spi_wdata(cmd_wdata, dec_offset, dec_mask) : 32'h0;
  assign gap_end     = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
  assign launch_go   = (idle && bus.req_valid && !(bus.req_write && (bus.req_wstrb == 4'b0000)))
                    || (gap_end && !err_q && (rem_q != 4'b0000));

  sram_strobe_decode u_decode (
    .strb_i    (dec_strb),
    .loop_i    (dec_loop),
    .direct_o  (dec_direct),
    .offset_o  (dec_offset),
    .mask_o    (dec_mask),
    .consume_o (dec_consume)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      word_q          <= '0;
      wdata_q         <= '0;
      write_q         <= 1'b0;
      loop_q          <= 1'b0;
      err_q           <= 1'b0;
      rem_q           <= '0;
      rdata_q         <= '0;
      tmo_cnt_q       <= '0;
      gap_cnt_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= '0;
      spi_reset_q     <= 1'b1;
      spi_addr_q      <= '0;
      spi_data_in_q   <= '0;
      spi_byte_mask_q <= '0;
      spi_write_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            word_q  <= bus.req_addr[23:2];
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            loop_q  <= !dec_direct;
            err_q   <= 1'b0;
            if (bus.req_write && (bus.req_wstrb == 4'b0000)) begin
              rem_q       <= '0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_LAUNCH: begin
          spi_reset_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.spi_valid) begin
            rdata_q     <= bus.spi_data_out;
            spi_reset_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            spi_reset_q <= 1'b1;
            err_q       <= 1'b1;
            gap_cnt_q   <= '0;
            state_q     <= ST_GAP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          gap_cnt_q <= '0;
          state_q   <= ST_GAP;
        end
        ST_GAP: begin
          if (!gap_end) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end else if (err_q || (rem_q == 4'b0000)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= (err_q || write_q) ? 32'h0 : byte_swap(rdata_q);
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          err_q       <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (launch_go) begin
        spi_addr_q      <= {cmd_word, dec_offset};
        spi_byte_mask_q <= dec_mask;
        spi_write_q     <= cmd_write;
        spi_data_in_q   <= cmd_data_in;
        rem_q           <= dec_strb & ~dec_consume;
        tmo_cnt_q       <= '0;
        state_q         <= ST_LAUNCH;
      end
    end
  end

  assign bus.req_ready     = idle & reset_n;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.spi_reset     = spi_reset_q;
  assign bus.spi_addr      = spi_addr_q;
  assign bus.spi_data_in   = spi_data_in_q;
  assign bus.spi_byte_mask = spi_byte_mask_q;
  assign bus.spi_write     = spi_write_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: behavioural spi_master + serial SRAM, request-level reference model,
// queued expectations checked by independent response and SPI monitors.
module tb_sram_bridge;

  localparam int TMO = 255;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sram_bridge_if bus ();

  sram_bridge #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  mask;
    logic [31:0] data;
    logic        wr;
  } spi_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  spi_t exp_spi[$];
  rsp_t exp_rsp[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rsp_cnt = 0;
  logic [31:0] last_rdata = '0;
  bit [7:0] sram    [0:1023];
  bit [7:0] ref_mem [0:1023];
  bit spi_disconnect = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic spi_t mk_txn(input logic [23:0] base, input int off, input int n,
                                  input logic [31:0] wd);
    spi_t t;
    t.addr = base + 24'(off);
    t.mask = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
    t.wr   = 1'b1;
    t.data = '0;
    for (int i = 0; i < n; i++) t.data[31-8*i -: 8] = wd[8*(off+i) +: 8];
    return t;
  endfunction

  // Reference: bytes land at aligned word + lane; regular strobes go as one burst, others per byte.
  task automatic issue_exp(input bit wr, input logic [23:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int mode);
    logic [23:0] base;
    int   b, n, lo;
    spi_t e;
    rsp_t r;
    base = {addr[23:2], 2'b00};
    b    = int'(base[9:0]);
    n    = 0;
    lo   = -1;
    r    = '{32'h0, 1'b0};
    if (!wr) begin
      e = '{base, 2'b10, 32'h0, 1'b0};
      exp_spi.push_back(e);
      r.rdata = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (st[k]) begin
          n++;
          if (lo < 0) lo = k;
          ref_mem[b+k] = wd[8*k +: 8];
        end
      end
      if (n > 0) begin
        if ((st == 4'(((1 << n) - 1) << lo)) && (n != 3)) begin
          exp_spi.push_back(mk_txn(base, lo, n, wd));
        end else begin
          for (int k = 0; k < 4; k++)
            if (st[k]) exp_spi.push_back(mk_txn(base, k, 1, wd));
        end
      end
    end
    if (mode == 1) r = '{32'h0, 1'b1};
    if (mode != 2) exp_rsp.push_back(r);
  endtask

  // mode 0: normal, 1: expect timeout error, 2: no response awaited (reset interrupts it)
  task automatic do_req(input bit wr, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int mode, output int lat);
    int k;
    int start;
    lat = 0;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_wait: req_ready stayed 0 for %0d cycles, want 1", k);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wstrb = st;
    issue_exp(wr, addr, wd, st, mode);
    start = rsp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 24'($urandom);
    bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom);
    if (wr && st == 4'b0000) chk("zero_strb_rsp_next_cycle", 64'(bus.rsp_valid), 64'(1));
    else                     chk("busy_not_ready", 64'(bus.req_ready), 64'(0));
    if (mode == 2) return;
    #1;
    k = 0;
    while (rsp_cnt == start && k < 600) begin
      @(negedge clk);
      #1;
      k++;
    end
    lat = k + 1;
    if (rsp_cnt == start) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles, want one", k);
    end
    @(negedge clk);
    chk("ready_after_rsp", 64'(bus.req_ready), 64'(1));
  endtask

  // Behavioural spi_master with a byte-addressed serial SRAM behind it.
  initial begin : spi_model
    spi_t cur, e;
    int   lat, n, hi_cnt;
    bit   active, stable;
    logic [31:0] d;
    active = 1'b0;
    stable = 1'b1;
    hi_cnt = 100;
    lat    = 0;
    bus.spi_valid    = 1'b0;
    bus.spi_busy     = 1'b0;
    bus.spi_data_out = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
        bus.spi_valid = 1'b0;
        bus.spi_busy  = 1'b0;
        hi_cnt = 100;
      end else if (!active) begin
        if (!bus.spi_reset) begin
          active = 1'b1;
          stable = 1'b1;
          lat    = $urandom_range(1, 6);
          bus.spi_busy = 1'b1;
          cur = '{bus.spi_addr, bus.spi_byte_mask, bus.spi_data_in, bus.spi_write};
          chk("spi_gap_high_cycles", 64'(hi_cnt >= GAP), 64'(1));
          if (exp_spi.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spi_unexpected: got transaction at 0x%0h, want none", cur.addr);
          end else begin
            e = exp_spi.pop_front();
            chk("spi_addr", 64'(cur.addr), 64'(e.addr));
            chk("spi_byte_mask", 64'(cur.mask), 64'(e.mask));
            chk("spi_write", 64'(cur.wr), 64'(e.wr));
            if (e.wr) chk("spi_data_in", 64'(cur.data), 64'(e.data));
          end
        end else begin
          hi_cnt++;
        end
      end else if (bus.spi_reset) begin
        chk("spi_cmd_stable", 64'(stable), 64'(1));
        active = 1'b0;
        bus.spi_valid = 1'b0;
        bus.spi_busy  = 1'b0;
        hi_cnt = 1;
      end else begin
        if ({bus.spi_addr, bus.spi_byte_mask, bus.spi_data_in, bus.spi_write} != cur) stable = 1'b0;
        if (!bus.spi_valid && !spi_disconnect) begin
          lat--;
          if (lat == 0) begin
            n = (cur.mask == 2'b00) ? 1 : (cur.mask == 2'b01) ? 2 : 4;
            d = $urandom;
            if (!cur.wr) d = '0;
            for (int i = 0; i < n; i++) begin
              if (cur.wr) sram[(int'(cur.addr[9:0]) + i) % 1024] = cur.data[31-8*i -: 8];
              else        d[31-8*i -: 8] = sram[(int'(cur.addr[9:0]) + i) % 1024];
            end
            bus.spi_data_out = d;
            bus.spi_valid    = 1'b1;
            bus.spi_busy     = 1'b0;
          end
        end
      end
    end
  end

  initial begin : rsp_monitor
    bit   prev;
    rsp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.rsp_valid) begin
        rsp_cnt++;
        last_rdata = bus.rsp_rdata;
        chk("rsp_single_cycle", 64'(prev), 64'(0));
        chk("ready_low_in_rsp", 64'(bus.req_ready), 64'(0));
        if (exp_rsp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got rsp rdata 0x%0h, want no response", bus.rsp_rdata);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
      prev = reset_n && bus.rsp_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
    chk({tag, "_spi_reset"}, 64'(bus.spi_reset), 64'(1));
    chk({tag, "_spi_addr"}, 64'(bus.spi_addr), 64'(0));
    chk({tag, "_spi_data_in"}, 64'(bus.spi_data_in), 64'(0));
    chk({tag, "_spi_byte_mask"}, 64'(bus.spi_byte_mask), 64'(0));
    chk({tag, "_spi_write"}, 64'(bus.spi_write), 64'(0));
  endtask

  initial begin : main
    int lat;
    bit wr;
    logic [7:0] v;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    for (int i = 0; i < 1024; i++) begin
      v = 8'($urandom);
      sram[i]    = v;
      ref_mem[i] = v;
    end

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    #2 reset_n = 1'b1;
    #1 chk("ready_first_cycle_after_por", 64'(bus.req_ready), 64'(1));
    @(negedge clk);

    do_req(1'b1, 24'h000100, 32'hDDCCBBAA, 4'b1111, 0, lat);
    do_req(1'b0, 24'h000100, 32'h0, 4'b0000, 0, lat);
    chk("word_rdback_0x100", 64'(last_rdata), 64'(32'hDDCCBBAA));
    do_req(1'b1, 24'h000102, 32'h5566_0000, 4'b1100, 0, lat);
    do_req(1'b0, 24'h000100, 32'h0, 4'b0000, 0, lat);
    chk("halfword_merge_0x100", 64'(last_rdata), 64'(32'h5566BBAA));
    do_req(1'b1, 24'h000200, 32'h0011_0022, 4'b0101, 0, lat);
    do_req(1'b1, 24'h000300, 32'h1234_5678, 4'b0000, 0, lat);
    chk("zero_strb_latency", 64'(lat), 64'(1));
    do_req(1'b0, 24'h000200, 32'h0, 4'b0000, 0, lat);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr = 1'($urandom);
      do_req(wr, 24'($urandom_range(0, 255)), $urandom, 4'($urandom), 0, lat);
    end

    spi_disconnect = 1'b1;
    do_req(1'b0, 24'h000100, 32'h0, 4'b0000, 1, lat);
    chk("timeout_latency_window", 64'((lat >= TMO + 2) && (lat <= TMO + 8)), 64'(1));
    spi_disconnect = 1'b0;
    do_req(1'b0, 24'h000100, 32'h0, 4'b0000, 0, lat);

    spi_disconnect = 1'b1;
    do_req(1'b0, 24'h000104, 32'h0, 4'b0000, 2, lat);
    repeat (20) @(negedge clk);
    chk("spi_running_in_wait", 64'(bus.spi_reset), 64'(0));
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid_wait_rst");
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 chk("ready_first_cycle_after_rst", 64'(bus.req_ready), 64'(1));
    spi_disconnect = 1'b0;
    repeat (30) @(negedge clk);
    do_req(1'b0, 24'h000200, 32'h0, 4'b0000, 0, lat);
    do_req(1'b1, 24'h000204, 32'hCAFE_F00D, 4'b1011, 0, lat);
    do_req(1'b0, 24'h000204, 32'h0, 4'b0000, 0, lat);

    repeat (5) @(negedge clk);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));
    chk("spi_queue_drained", 64'(exp_spi.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum clk cycles spent waiting for spi_valid per SPI transaction.
REQ-002 Parameter GAP_CYCLES, default 2: minimum clk cycles spi_reset is held high between SPI transactions.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU memory request present.
REQ-006 req_ready  output  1  bridge accepts a request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  24  byte address.
REQ-009 req_wdata  input  32  write data, little-endian lanes (lane k = bits 8k+7:8k).
REQ-010 req_wstrb  input  4  write byte enables; ignored on reads.
REQ-011 rsp_valid  output  1  one-cycle response pulse.
REQ-012 rsp_rdata  output  32  read data, little-endian lanes.
REQ-013 rsp_err  output  1  response terminated by timeout.
REQ-014 spi_reset  output  1  hold/start to spi_master; high = idle, low = run.
REQ-015 spi_addr, spi_data_in, spi_byte_mask, spi_write  output  24/32/2/1  spi_master command fields.
REQ-016 spi_data_out, spi_busy, spi_valid  input  32/1/1  spi_master results and status.

Function
REQ-017 States: IDLE, LAUNCH, WAIT, DONE, GAP, RESP.
REQ-018 req_ready shall be 1 only in IDLE; handshake on req_valid && req_ready latches all req_* fields; later changes to req_* are ignored.
REQ-019 Read: one SPI transaction, 4 bytes at {req_addr[23:2],2'b00}, spi_byte_mask=2'b10, spi_write=0.
REQ-020 Write with req_wstrb in {0001,0010,0100,1000} -> one 1-byte transaction (mask 2'b00); {0011,0110,1100} -> one 2-byte transaction (mask 2'b01); 1111 -> one 4-byte transaction (mask 2'b10); start offset = lowest set strobe bit.
REQ-021 Any other nonzero strobe -> one 1-byte transaction per set bit, ascending lane order.
REQ-022 Write with req_wstrb=0000 -> no SPI activity; IDLE->RESP, response next cycle.
REQ-023 spi_addr = {req_addr[23:2], offset}; first SPI byte lands at spi_addr.
REQ-024 spi_data_in MSB-first: bits 31:24 = lane(offset), 23:16 = lane(offset+1), etc.; unused low bits 0.
REQ-025 Read data: rsp_rdata = {spi_data_out[7:0], [15:8], [23:16], [31:24]} (byte swap).
REQ-026 LAUNCH: drive command fields, spi_reset=1 for one cycle; then WAIT with spi_reset=0.
REQ-027 spi_addr, spi_data_in, spi_byte_mask, spi_write shall be stable from LAUNCH until spi_reset rises again.
REQ-028 WAIT -> DONE on spi_valid=1; DONE captures spi_data_out and drives spi_reset=1.
REQ-029 DONE -> GAP; GAP holds spi_reset=1 for GAP_CYCLES, then LAUNCH next byte if bytes remain, else RESP.
REQ-030 RESP: rsp_valid=1 for exactly one cycle, then IDLE; earliest next accept is the following cycle.
REQ-031 Timeout: an 8-bit+ counter cleared on LAUNCH, incremented in WAIT; reaching TIMEOUT_CYCLES -> spi_reset=1, remaining bytes dropped, GAP then RESP with rsp_err=1, rsp_rdata=0.
REQ-032 spi_busy is status only; no transition depends on it.
REQ-033 rsp_rdata on writes shall be 0; rsp_err=0 on normal completion.

Reset
REQ-034 reset_n low (any cycle, incl. mid-transaction) forces IDLE immediately: req_ready=0 while asserted, rsp_valid=0, rsp_err=0, rsp_rdata=0, spi_reset=1, spi_addr=0, spi_data_in=0, spi_byte_mask=0, spi_write=0, counters 0.
REQ-035 First cycle after reset_n rises: IDLE, req_ready=1; an interrupted request produces no response.

Structure
REQ-036 Shared package holds state enum, byte_mask encodings (1/2/4 bytes = 00/01/10) and SPI byte-swap function.
REQ-037 One sub-module sram_strobe_decode (combinational: strobe -> direct/loop, offset, mask) is natural; rest is single FSM.

Verification
REQ-038 Bench uses real spi_master plus behavioural 23LC-style SRAM model.
REQ-039 Write addr 0x000100, wdata 0xDDCCBBAA, wstrb 1111, then read 0x000100 -> spi_data_in 0xAABBCCDD, rsp_rdata 0xDDCCBBAA, rsp_err=0.
REQ-040 Write addr 0x000102, wdata 0x5566_0000, wstrb 1100 -> one transaction, spi_addr 0x000102, mask 01, data_in 0x6655_0000; read word 0x000100 -> 0x5566BBAA.
REQ-041 Write wstrb 0101, wdata 0x00110022 at 0x000200 -> two 1-byte transactions at 0x000200 (0x22) and 0x000202 (0x11), spi_reset high >= 2 cycles between, one rsp_valid.
REQ-042 Write wstrb 0000 -> rsp_valid one cycle after accept, spi_reset never low.
REQ-043 Disconnect spi_valid (tie 0), read -> rsp_err=1, rsp_rdata=0 after TIMEOUT_CYCLES+~4 cycles; reset_n pulse mid-WAIT -> spi_reset=1 same cycle, no response.
